nvio_slot_enqueue: RTL and testbench

Enqueue-side counterpart to the fetch slot-valid tracker. Each cycle it decides how many valid slots of the current instruction bundle enter the re-order queue. It drives `queuedCnt`, the per-slot `lsm` hold mask and `nextb` back to the slot-valid tracker, and owns the queue tail pointer. Load/store-multiple (LSM) slots are expanded into one queue entry per register over successive cycles.

---
 rtl/nvio_pkg.sv | 17 +
 rtl/nvio_contig_cnt.sv | 34 +++
 rtl/nvio_slot_enqueue.sv | 189 ++++++++++++++++++
 tb/tb_nvio_slot_enqueue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nvio_pkg.sv
// Shared definitions for the nvio enqueue slice: enqueue FSM states,
// default queue depth and a 3-bit population count.
package nvio_pkg;

  localparam int NVIO_QENTRIES = 16;
  localparam int NSLOTS        = 3;

  typedef enum logic {
    ENQ_IDLE = 1'b0,
    ENQ_LSM  = 1'b1
  } enq_state_e;

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/nvio_contig_cnt.sv
// Finds the lowest valid slot and the length of the contiguous run of
// valid non-LSM slots starting there.
module nvio_contig_cnt
  import nvio_pkg::*;
(
  input  logic [NSLOTS-1:0] slotv,
  input  logic [NSLOTS-1:0] slot_lsm,
  output logic [1:0]        run_len,
  output logic [NSLOTS-1:0] low_oh
);

  logic found;
  logic stop;

  always_comb begin
    run_len = '0;
    low_oh  = '0;
    found   = 1'b0;
    stop    = 1'b0;
    for (int unsigned i = 0; i < NSLOTS; i++) begin
      if (!found && slotv[i]) begin
        found     = 1'b1;
        low_oh[i] = 1'b1;
      end
      if (found && !stop) begin
        if (slotv[i] && !slot_lsm[i])
          run_len = run_len + 2'd1;
        else
          stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nvio_slot_enqueue.sv
// Enqueue-side slot sequencer: picks bundle slots for the re-order queue,
// expands LSM slots into per-register micro-ops (when NVIO_LSM_EN is defined)
// and owns the queue tail pointer.
module nvio_slot_enqueue
  import nvio_pkg::*;
#(
  parameter int QSLOTS   = 3,
  parameter int QENTRIES = NVIO_QENTRIES,
  parameter int AMSB     = $clog2(QENTRIES) - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branchmiss,
  input  logic [AMSB:0]       miss_tail,
  input  logic [QSLOTS-1:0]   slotv,
  input  logic [QSLOTS-1:0]   slot_lsm,
  input  logic [5*QSLOTS-1:0] lsm_cnt,
  input  logic [AMSB+1:0]     free_cnt,
  input  logic                debug_on,
  output logic [2:0]          queuedCnt,
  output logic [QSLOTS-1:0]   queued_on,
  output logic [QSLOTS-1:0]   lsm,
  output logic [4:0]          lsm_idx,
  output logic [AMSB:0]       tail0,
  output logic [AMSB:0]       tail1,
  output logic [AMSB:0]       tail2,
  output logic                nextb
);

  logic [AMSB:0]       tail;
  enq_state_e          state, state_nxt;
  logic [4:0]          idx, idx_nxt;
  logic [QSLOTS-1:0]   lsm_slot, lsm_slot_nxt;

  logic [QSLOTS-1:0]   slot_lsm_m;
  logic [5*QSLOTS-1:0] lsm_cnt_m;

`ifdef NVIO_LSM_EN
  assign slot_lsm_m = slot_lsm;
  assign lsm_cnt_m  = lsm_cnt;
`else
  // With sequencing disabled no slot is ever LSM, so the LSM state is unreachable.
  logic unused_lsm_inputs;
  assign slot_lsm_m        = '0;
  assign lsm_cnt_m         = '0;
  assign unused_lsm_inputs = ^{slot_lsm, lsm_cnt};
`endif

  logic [1:0]        run_len;
  logic [QSLOTS-1:0] low_oh;

  nvio_contig_cnt u_contig (
    .slotv    (slotv),
    .slot_lsm (slot_lsm_m),
    .run_len  (run_len),
    .low_oh   (low_oh)
  );

  // Register count of the slot being sequenced (held slot in LSM, lowest slot in IDLE).
  logic [QSLOTS-1:0] cnt_sel_oh;
  logic [4:0]        cnt_sel;
  logic [4:0]        eff_cnt;

  always_comb begin
    cnt_sel_oh = (state == ENQ_LSM) ? lsm_slot : low_oh;
    cnt_sel    = '0;
    for (int unsigned i = 0; i < QSLOTS; i++)
      if (cnt_sel_oh[i])
        cnt_sel = cnt_sel | lsm_cnt_m[5*i +: 5];
    eff_cnt = (cnt_sel == 5'd0) ? 5'd1 : cnt_sel;
  end

  logic [1:0]        lim;
  logic [1:0]        n_plain;
  logic [1:0]        lo;
  logic [QSLOTS-1:0] run_mask;
  logic [QSLOTS-1:0] plain_on;
  logic              free_nz;

  always_comb begin
    lim     = debug_on ? 2'd1 : 2'd3;
    free_nz = (free_cnt != '0);
    n_plain = run_len;
    if (lim < n_plain)
      n_plain = lim;
    if (free_cnt < (AMSB+2)'(n_plain))
      n_plain = free_cnt[1:0];
    lo = low_oh[0] ? 2'd0 : (low_oh[1] ? 2'd1 : 2'd2);
    case (n_plain)
      2'd0:    run_mask = 3'b000;
      2'd1:    run_mask = 3'b001;
      2'd2:    run_mask = 3'b011;
      default: run_mask = 3'b111;
    endcase
    plain_on = run_mask << lo;
  end

  logic [QSLOTS-1:0] retired;

  always_comb begin
    queuedCnt    = '0;
    queued_on    = '0;
    lsm          = '0;
    lsm_idx      = '0;
    nextb        = 1'b0;
    retired      = '0;
    state_nxt    = state;
    idx_nxt      = idx;
    lsm_slot_nxt = lsm_slot;

    if (rst || branchmiss) begin
      state_nxt    = ENQ_IDLE;
      idx_nxt      = '0;
      lsm_slot_nxt = '0;
    end else if (state == ENQ_LSM) begin
      lsm_idx = idx;
      lsm     = lsm_slot;
      if (free_nz) begin
        queued_on = lsm_slot;
        if (idx == eff_cnt - 5'd1) begin
          queuedCnt    = 3'd1;
          retired      = lsm_slot;
          lsm          = '0;
          state_nxt    = ENQ_IDLE;
          idx_nxt      = '0;
          lsm_slot_nxt = '0;
        end else begin
          idx_nxt = idx + 5'd1;
        end
      end
      nextb = ((slotv & ~retired) == '0);
    end else begin
      lsm_idx = idx;
      if ((low_oh & slot_lsm_m) != '0) begin
        if (free_nz) begin
          queued_on = low_oh;
          if (eff_cnt == 5'd1) begin
            queuedCnt = 3'd1;
            retired   = low_oh;
          end else begin
            lsm          = low_oh;
            state_nxt    = ENQ_LSM;
            idx_nxt      = 5'd1;
            lsm_slot_nxt = low_oh;
          end
        end
      end else begin
        queued_on = plain_on;
        queuedCnt = {1'b0, n_plain};
        retired   = plain_on;
      end
      nextb = ((slotv & ~retired) == '0);
    end
  end

  // Tags follow the reset value of tail while rst is held, and blank on a flush.
  logic [AMSB:0] tag_base;

  always_comb begin
    tag_base = rst ? '0 : tail;
    if (branchmiss && !rst) begin
      tail0 = '0;
      tail1 = '0;
      tail2 = '0;
    end else begin
      tail0 = tag_base;
      tail1 = tag_base + (AMSB+1)'(1);
      tail2 = tag_base + (AMSB+1)'(2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tail     <= '0;
      state    <= ENQ_IDLE;
      idx      <= '0;
      lsm_slot <= '0;
    end else begin
      if (branchmiss)
        tail <= miss_tail;
      else
        tail <= tail + (AMSB+1)'(popcnt3(queued_on));
      state    <= state_nxt;
      idx      <= idx_nxt;
      lsm_slot <= lsm_slot_nxt;
    end
  end

endmodule

// File: tb/tb_nvio_slot_enqueue.sv
// Directed self-checking bench for nvio_slot_enqueue; LSM sequencing
// vectors are selected by NVIO_LSM_EN to match the RTL build.
module tb_nvio_slot_enqueue;

  logic        clk = 1'b0;
  logic        rst;
  logic        branchmiss;
  logic [3:0]  miss_tail;
  logic [2:0]  slotv;
  logic [2:0]  slot_lsm;
  logic [14:0] lsm_cnt;
  logic [4:0]  free_cnt;
  logic        debug_on;
  logic [2:0]  queuedCnt;
  logic [2:0]  queued_on;
  logic [2:0]  lsm;
  logic [4:0]  lsm_idx;
  logic [3:0]  tail0, tail1, tail2;
  logic        nextb;

  int n_tests = 0;
  int n_fail  = 0;

  nvio_slot_enqueue #(.QSLOTS(3), .QENTRIES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .branchmiss (branchmiss),
    .miss_tail  (miss_tail),
    .slotv      (slotv),
    .slot_lsm   (slot_lsm),
    .lsm_cnt    (lsm_cnt),
    .free_cnt   (free_cnt),
    .debug_on   (debug_on),
    .queuedCnt  (queuedCnt),
    .queued_on  (queued_on),
    .lsm        (lsm),
    .lsm_idx    (lsm_idx),
    .tail0      (tail0),
    .tail1      (tail1),
    .tail2      (tail2),
    .nextb      (nextb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; branchmiss = 1'b0; miss_tail = '0;
    slotv = 3'b111; slot_lsm = '0; lsm_cnt = '0; free_cnt = 5'd8; debug_on = 1'b0;
    #2;
    check("rst_qcnt", queuedCnt, 0);
    check("rst_qon", queued_on, 0);
    check("rst_nextb", nextb, 0);
    check("rst_lsm", lsm, 0);
    check("rst_lsmidx", lsm_idx, 0);
    check("rst_tag0", tail0, 0);
    check("rst_tag1", tail1, 1);
    check("rst_tag2", tail2, 2);

    // move tail to 5 through a flush
    tick(); rst = 1'b0; branchmiss = 1'b1; miss_tail = 4'd5; settle();
    check("miss_qcnt", queuedCnt, 0);
    check("miss_qon", queued_on, 0);
    check("miss_nextb", nextb, 0);

    tick(); branchmiss = 1'b0; slotv = 3'b111; free_cnt = 5'd8; settle();
    check("plain_qcnt", queuedCnt, 3);
    check("plain_qon", queued_on, 3'b111);
    check("plain_tag0", tail0, 5);
    check("plain_tag1", tail1, 6);
    check("plain_tag2", tail2, 7);
    check("plain_nextb", nextb, 1);

    tick(); slotv = 3'b000; settle();
    check("plain_tail", tail0, 8);
    check("empty_nextb", nextb, 1);
    check("empty_qcnt", queuedCnt, 0);

    slotv = 3'b111; free_cnt = 5'd2; settle();
    check("lim_qcnt", queuedCnt, 2);
    check("lim_qon", queued_on, 3'b011);
    check("lim_nextb", nextb, 0);
    tick(); slotv = 3'b100; settle();
    check("lim2_qcnt", queuedCnt, 1);
    check("lim2_qon", queued_on, 3'b100);
    check("lim2_nextb", nextb, 1);
    check("lim2_tag0", tail0, 10);

    tick(); slotv = 3'b111; free_cnt = 5'd0; settle();
    check("stall_qon", queued_on, 0);
    check("stall_qcnt", queuedCnt, 0);
    check("stall_nextb", nextb, 0);
    tick(); settle();
    check("stall_tail", tail0, 11);

    debug_on = 1'b1; free_cnt = 5'd8; slotv = 3'b111; settle();
    check("dbg1_qcnt", queuedCnt, 1);
    check("dbg1_qon", queued_on, 3'b001);
    check("dbg1_nextb", nextb, 0);
    tick(); slotv = 3'b110; settle();
    check("dbg2_qcnt", queuedCnt, 1);
    check("dbg2_qon", queued_on, 3'b010);
    tick(); slotv = 3'b100; settle();
    check("dbg3_qcnt", queuedCnt, 1);
    check("dbg3_qon", queued_on, 3'b100);
    check("dbg3_nextb", nextb, 1);
    tick(); debug_on = 1'b0; slotv = 3'b111; settle();
    check("wrap_tag0", tail0, 14);
    check("wrap_tag1", tail1, 15);
    check("wrap_tag2", tail2, 0);
    tick(); slotv = 3'b000; settle();
    check("wrap_tail", tail0, 1);

    // run of two plain slots stops at an LSM slot
    slotv = 3'b111; slot_lsm = 3'b100; lsm_cnt = {5'd3, 10'd0}; settle();
`ifdef NVIO_LSM_EN
    check("mix_qcnt", queuedCnt, 2);
    check("mix_qon", queued_on, 3'b011);
    check("mix_nextb", nextb, 0);
`else
    check("mix_qcnt", queuedCnt, 3);
    check("mix_qon", queued_on, 3'b111);
    check("mix_nextb", nextb, 1);
`endif
    slotv = 3'b000; slot_lsm = '0; lsm_cnt = '0; settle();

`ifdef NVIO_LSM_EN
    slotv = 3'b010; slot_lsm = 3'b010; lsm_cnt = {5'd0, 5'd4, 5'd0}; settle();
    check("lsm1_lsm", lsm, 3'b010);
    check("lsm1_idx", lsm_idx, 0);
    check("lsm1_qcnt", queuedCnt, 0);
    check("lsm1_qon", queued_on, 3'b010);
    check("lsm1_nextb", nextb, 0);
    tick(); free_cnt = 5'd0; settle();
    check("lsmst_qon", queued_on, 0);
    check("lsmst_lsm", lsm, 3'b010);
    check("lsmst_idx", lsm_idx, 1);
    tick(); free_cnt = 5'd8; settle();
    check("lsm2_idx", lsm_idx, 1);
    check("lsm2_qcnt", queuedCnt, 0);
    check("lsm2_lsm", lsm, 3'b010);
    tick(); settle();
    check("lsm3_idx", lsm_idx, 2);
    check("lsm3_lsm", lsm, 3'b010);
    tick(); settle();
    check("lsm4_idx", lsm_idx, 3);
    check("lsm4_qcnt", queuedCnt, 1);
    check("lsm4_lsm", lsm, 0);
    check("lsm4_nextb", nextb, 1);
    tick(); slotv = 3'b000; slot_lsm = '0; settle();
    check("lsm_tail", tail0, 5);

    // flush at idx 2
    slotv = 3'b010; slot_lsm = 3'b010; settle();
    tick(); tick(); settle();
    check("fl_pre_idx", lsm_idx, 2);
    branchmiss = 1'b1; miss_tail = 4'd9; settle();
    check("fl_qcnt", queuedCnt, 0);
    check("fl_qon", queued_on, 0);
    check("fl_lsm", lsm, 0);
    check("fl_idx", lsm_idx, 0);
    check("fl_nextb", nextb, 0);
    tick(); branchmiss = 1'b0; slotv = 3'b000; slot_lsm = '0; settle();
    check("fl_tail", tail0, 9);
    check("fl_post_idx", lsm_idx, 0);
    check("fl_post_lsm", lsm, 0);
    check("fl_post_nextb", nextb, 1);

    // reset in the middle of sequencing
    slotv = 3'b010; slot_lsm = 3'b010; settle();
    tick(); rst = 1'b1; settle();
    check("rl_qon", queued_on, 0);
    check("rl_lsm", lsm, 0);
    check("rl_tag1", tail1, 1);
    tick(); rst = 1'b0; settle();
    check("rl_tail", tail0, 0);
    check("rl_idx", lsm_idx, 0);
    check("rl_restart_lsm", lsm, 3'b010);
    check("rl_restart_qcnt", queuedCnt, 0);
    tick(); rst = 1'b1; tick(); rst = 1'b0; settle();

    // single-register LSM completes in one cycle
    slotv = 3'b001; slot_lsm = 3'b001; lsm_cnt = {10'd0, 5'd1}; settle();
    check("one_qcnt", queuedCnt, 1);
    check("one_qon", queued_on, 3'b001);
    check("one_lsm", lsm, 0);
    check("one_nextb", nextb, 1);
`else
    slotv = 3'b010; slot_lsm = 3'b010; lsm_cnt = {5'd0, 5'd4, 5'd0}; settle();
    check("nolsm_qcnt", queuedCnt, 1);
    check("nolsm_qon", queued_on, 3'b010);
    check("nolsm_lsm", lsm, 0);
    check("nolsm_idx", lsm_idx, 0);
    check("nolsm_nextb", nextb, 1);
    tick(); slotv = 3'b000; settle();
    check("nolsm_tail", tail0, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
